fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 204 ++++++++++++++++++++
 tb/tb_fetch_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch unit. Keeps one request outstanding to the
//                instruction memory, presents fetched words to decode through
//                an output register with a one-entry overflow buffer, and
//                restarts fetch on branch redirects. Responses belonging to
//                a flushed path are squashed.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC,
   input  logic        Stall,
   output logic        IMemReqValid,
   output logic [31:0] IMemAddr,
   input  logic        IMemReqReady,
   input  logic        IMemRespValid,
   input  logic [31:0] IMemRespData,
   output logic        InstrValid,
   output logic [31:0] Instruction,
   output logic [31:0] InstrPC
);

   // IDLE: one cycle after reset; REQ: request on the bus; WAIT: request
   // outstanding; HOLD: overflow buffer full, waiting for decode to drain.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;

   // Fetch-side registers
   logic [31:0] fetch_pc;
   logic [31:0] fetch_pc_nxt;
   logic [31:0] req_pc;
   logic [31:0] req_pc_nxt;
   logic        req_valid;
   logic        req_valid_nxt;
   logic        squash;
   logic        squash_nxt;

   // One-entry overflow buffer; its contents are meaningful only in HOLD
   logic [31:0] buf_data;
   logic [31:0] buf_data_nxt;
   logic [31:0] buf_pc;
   logic [31:0] buf_pc_nxt;

   // Decode-facing output register
   logic        out_valid;
   logic        out_valid_nxt;
   logic [31:0] out_instr;
   logic [31:0] out_instr_nxt;
   logic [31:0] out_pc;
   logic [31:0] out_pc_nxt;

   logic        accept;
   logic        consume;

   assign accept  = req_valid & IMemReqReady;
   assign consume = out_valid & ~Stall;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and next-register-value logic; Redirect overrides the
   // normal flow at the end so it wins over every other event.
   always_comb begin
      state_nxt     = state;
      fetch_pc_nxt  = fetch_pc;
      req_pc_nxt    = req_pc;
      squash_nxt    = squash;
      buf_data_nxt  = buf_data;
      buf_pc_nxt    = buf_pc;
      out_valid_nxt = out_valid;
      out_instr_nxt = out_instr;
      out_pc_nxt    = out_pc;

      // A consumed instruction leaves the output register unless reloaded below
      if (consume) begin
         out_valid_nxt = 1'b0;
      end

      unique case (state)
         IDLE: begin
            state_nxt = REQ;
         end
         REQ: begin
            if (accept) begin
               state_nxt    = WAIT;
               req_pc_nxt   = fetch_pc;
               fetch_pc_nxt = fetch_pc + 32'd4;
            end
         end
         WAIT: begin
            if (IMemRespValid) begin
               state_nxt = REQ;
               if (squash) begin
                  // Response of a flushed path: drop it
                  squash_nxt = 1'b0;
               end else if (!out_valid || consume) begin
                  out_valid_nxt = 1'b1;
                  out_instr_nxt = IMemRespData;
                  out_pc_nxt    = req_pc;
               end else begin
                  // Decode is stalled on an occupied output: park the word
                  buf_data_nxt = IMemRespData;
                  buf_pc_nxt   = req_pc;
                  state_nxt    = HOLD;
               end
            end
         end
         HOLD: begin
            if (consume) begin
               out_valid_nxt = 1'b1;
               out_instr_nxt = buf_data;
               out_pc_nxt    = buf_pc;
               state_nxt     = REQ;
            end
         end
      endcase

      if (Redirect) begin
         fetch_pc_nxt  = RedirectPC;
         out_valid_nxt = 1'b0;
         case (state)
            REQ: begin
               if (accept) begin
                  // The request leaving now belongs to the old path
                  squash_nxt = 1'b1;
                  state_nxt  = WAIT;
               end else begin
                  state_nxt  = REQ;
               end
            end
            WAIT: begin
               if (IMemRespValid) begin
                  // The old-path response arrives with the redirect: drop it
                  // here, since no further response will come for it.
                  squash_nxt = 1'b0;
                  state_nxt  = REQ;
               end else begin
                  squash_nxt = 1'b1;
                  state_nxt  = WAIT;
               end
            end
            default: begin
               // IDLE, or HOLD whose buffered word is discarded
               state_nxt = REQ;
            end
         endcase
      end

      // Request strobe is registered so no input reaches it combinationally
      req_valid_nxt = (state_nxt == REQ);
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc  <= RESET_PC;
         req_pc    <= 32'h0;
         req_valid <= 1'b0;
         squash    <= 1'b0;
         buf_data  <= 32'h0;
         buf_pc    <= 32'h0;
         out_valid <= 1'b0;
         out_instr <= 32'h0;
         out_pc    <= 32'h0;
      end else begin
         fetch_pc  <= fetch_pc_nxt;
         req_pc    <= req_pc_nxt;
         req_valid <= req_valid_nxt;
         squash    <= squash_nxt;
         buf_data  <= buf_data_nxt;
         buf_pc    <= buf_pc_nxt;
         out_valid <= out_valid_nxt;
         out_instr <= out_instr_nxt;
         out_pc    <= out_pc_nxt;
      end
   end

   assign IMemReqValid = req_valid;
   assign IMemAddr     = fetch_pc;
   assign InstrValid   = out_valid;
   assign Instruction  = out_instr;
   assign InstrPC      = out_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit: directed scenarios plus
//                randomized traffic scored by a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h4000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        req_valid;
   logic [31:0] addr;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        instr_valid;
   logic [31:0] instruction;
   logic [31:0] instr_pc;

   int total = 0;
   int bad   = 0;

   // Memory configuration driven by the stimulus
   int          mem_lat  = 1;
   bit          mem_rand = 1'b0;
   bit          ovr_en   = 1'b0;
   logic [31:0] ovr_val  = 32'hDEAD_BEEF;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Redirect     (redirect),
      .RedirectPC   (redirect_pc),
      .Stall        (stall),
      .IMemReqValid (req_valid),
      .IMemAddr     (addr),
      .IMemReqReady (req_ready),
      .IMemRespValid(resp_valid),
      .IMemRespData (resp_data),
      .InstrValid   (instr_valid),
      .Instruction  (instruction),
      .InstrPC      (instr_pc)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == RESET_PC) return 32'h2408_0001;
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // Instruction memory: one request at a time, response 'lat' cycles after
   // acceptance, cleared by the same reset.
   logic        acc_s, rv_s, rst_s;
   logic [31:0] a_s, p_addr;
   bit          pend;
   int          cnt;
   initial begin
      resp_valid = 1'b0;
      resp_data  = 32'h0;
      pend       = 1'b0;
      cnt        = 0;
      p_addr     = 32'h0;
      forever begin
         @(negedge clk);
         acc_s = req_valid & req_ready;
         a_s   = addr;
         rv_s  = resp_valid;
         rst_s = rst_n;
         @(posedge clk);
         #2;
         if (rst_s !== 1'b1) begin
            pend = 1'b0;
         end else begin
            if (rv_s) pend = 1'b0;
            if (acc_s === 1'b1) begin
               pend   = 1'b1;
               p_addr = a_s;
               cnt    = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
            end else if (pend) begin
               cnt--;
            end
         end
         resp_valid = pend && (cnt == 1);
         resp_data  = resp_valid ? (ovr_en ? ovr_val : mem_word(p_addr)) : 32'h0;
      end
   end

   // Transaction-level reference: the words decode must see, in order,
   // are the live responses; a redirect flushes everything not yet consumed
   // and restarts the expected fetch stream at the target.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } ent_t;
   ent_t        q[$];
   bit          m_out;
   bit          m_live;
   logic [31:0] m_pc;
   logic [31:0] m_fetch;
   int          idle_cnt;
   int          delivered = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            q.delete();
            m_out    = 1'b0;
            m_live   = 1'b0;
            m_fetch  = RESET_PC;
            idle_cnt = 0;
         end else begin
            check("valid_vs_model", instr_valid, (q.size() != 0));
            if (instr_valid && q.size() != 0) begin
               check("instr_pc", instr_pc, q[0].pc);
               check("instruction", instruction, q[0].data);
            end
            if (req_valid) begin
               check("one_outstanding", m_out, 1'b0);
               check("req_addr", addr, m_fetch);
               check("no_req_when_full", (q.size() >= 2), 1'b0);
            end
            if (instr_valid && !stall && q.size() != 0) begin
               void'(q.pop_front());
               delivered++;
            end
            if (resp_valid) begin
               if (m_out && m_live && !redirect) q.push_back('{pc: m_pc, data: resp_data});
               m_out = 1'b0;
               check("queue_depth", (q.size() > 2), 1'b0);
            end
            if (req_valid && req_ready) begin
               m_out  = 1'b1;
               m_pc   = addr;
               m_live = !redirect;
               m_fetch = addr + 32'd4;
            end
            if (redirect) begin
               q.delete();
               m_live  = 1'b0;
               m_fetch = redirect_pc;
            end
            if (req_valid || resp_valid || (instr_valid && !stall)) idle_cnt = 0;
            else idle_cnt++;
            if (idle_cnt > 30) begin
               check("stuck", idle_cnt, 0);
               idle_cnt = 0;
            end
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      redirect = 1'b0;
      stall    = 1'b0;
      nxt();
      nxt();
      rst_n = 1'b1;
   endtask

   // Stimulus: directed scenarios, then random traffic
   initial begin
      rst_n       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      stall       = 1'b0;
      req_ready   = 1'b1;

      // Reset, sequential fetch and stall/buffer scenario
      do_reset();
      @(negedge clk);
      check("rst_req_valid", req_valid, 1'b0);
      check("rst_instr_valid", instr_valid, 1'b0);
      check("rst_instruction", instruction, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
      check("rst_addr", addr, RESET_PC);
      nxt(); @(negedge clk);
      check("c2_req_valid", req_valid, 1'b1);
      check("c2_addr", addr, RESET_PC);
      nxt(); @(negedge clk);
      check("c3_instr_valid", instr_valid, 1'b0);
      nxt(); @(negedge clk);
      check("c4_instr_valid", instr_valid, 1'b1);
      check("c4_instr_pc", instr_pc, RESET_PC);
      check("c4_instruction", instruction, 32'h2408_0001);
      for (int c = 5; c <= 8; c++) begin
         nxt();
         if (c == 8) stall = 1'b1;
         @(negedge clk);
         check("seq_valid", instr_valid, (c % 2 == 0));
         check("seq_req_valid", req_valid, (c % 2 == 0));
         if (c % 2 == 0) begin
            check("seq_instr_pc", instr_pc, RESET_PC + 32'(2 * (c - 4)));
            check("seq_addr", addr, RESET_PC + 32'(2 * (c - 2)));
         end
      end
      for (int c = 9; c <= 14; c++) begin
         nxt();
         if (c == 14) stall = 1'b0;
         @(negedge clk);
         check("stall_valid", instr_valid, 1'b1);
         check("stall_pc", instr_pc, RESET_PC + 32'h8);
         if (c >= 10 && c <= 13) check("hold_no_req", req_valid, 1'b0);
      end
      nxt(); @(negedge clk);
      check("buf_valid", instr_valid, 1'b1);
      check("buf_pc", instr_pc, RESET_PC + 32'hC);
      check("buf_data", instruction, mem_word(RESET_PC + 32'hC));
      check("after_hold_addr", addr, RESET_PC + 32'h10);
      nxt(); nxt(); @(negedge clk);
      check("after_hold_pc", instr_pc, RESET_PC + 32'h10);

      // Redirect during WAIT; the late response must be dropped
      mem_lat = 3;
      ovr_en  = 1'b1;
      do_reset();
      nxt();
      nxt(); redirect = 1'b1; redirect_pc = 32'h4000_0100;
      for (int c = 4; c <= 8; c++) begin
         nxt();
         redirect = 1'b0;
         if (c == 4) mem_lat = 1;
         if (c == 6) ovr_en = 1'b0;
         @(negedge clk);
         check("no_late_word", (instr_valid && instruction == 32'hDEAD_BEEF), 1'b0);
         if (c == 6) begin
            check("redir_valid_off", instr_valid, 1'b0);
            check("redir_req", req_valid, 1'b1);
            check("redir_addr", addr, 32'h4000_0100);
         end
      end
      check("redir_first_pc", instr_pc, 32'h4000_0100);
      check("redir_next_addr", addr, 32'h4000_0104);

      // Redirect in the accept cycle; then Redirect together with Stall
      do_reset();
      nxt(); redirect = 1'b1; redirect_pc = 32'h4000_0200;
      @(negedge clk);
      check("acc_redir_req", req_valid, 1'b1);
      nxt(); redirect = 1'b0;
      nxt(); @(negedge clk);
      check("acc_redir_addr", addr, 32'h4000_0200);
      check("acc_redir_valid", instr_valid, 1'b0);
      nxt();
      nxt(); redirect = 1'b1; redirect_pc = 32'h4000_0300; stall = 1'b1;
      @(negedge clk);
      check("rs_pre_pc", instr_pc, 32'h4000_0200);
      nxt(); redirect = 1'b0;
      @(negedge clk);
      check("rs_flush", instr_valid, 1'b0);
      nxt(); stall = 1'b0;
      @(negedge clk);
      check("rs_addr", addr, 32'h4000_0300);

      // Wrap of the fetch PC
      do_reset();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      nxt(); redirect = 1'b0;
      @(negedge clk);
      check("wrap_first", addr, 32'hFFFF_FFFC);
      nxt(); nxt(); @(negedge clk);
      check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
      check("wrap_addr", addr, 32'h0000_0000);

      // Random traffic
      do_reset();
      mem_rand = 1'b1;
      for (int i = 0; i < 6000; i++) begin
         nxt();
         rst_n       = ($urandom_range(0, 999) != 0);
         redirect    = ($urandom_range(0, 99) < 7);
         redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         stall       = ($urandom_range(0, 99) < 30);
         req_ready   = ($urandom_range(0, 99) < 75);
      end
      nxt();
      rst_n    = 1'b1;
      redirect = 1'b0;
      stall    = 1'b0;
      @(negedge clk);
      check("delivered_some", (delivered > 200), 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
